// File: rtl/hs32_pkg.sv
// Shared HS32 definitions: fetch packet layout, reset PC and a small
// address helper used by the fetch front-end.
package hs32_pkg;

    // Default program counter after reset.
    localparam logic [31:0] HS32_RESET_PC = 32'h0000_0000;

    // One buffered instruction: the word, its register bank tag and the
    // address it was fetched from.
    typedef struct packed {
        logic [31:0] op;
        logic        bank;
        logic [31:0] pc;
    } hs32_fetchpkt;

    localparam int HS32_FETCHPKT_W = $bits(hs32_fetchpkt);

    // Force an address onto a word boundary (the low two bits are ignored).
    function automatic logic [31:0] hs32_word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/hs32_fifo.sv
// Shared primitive: synchronous FIFO with a flush. Storage is a plain
// register array; the head entry is read straight from that array, so the
// output only ever changes on a clock edge.
module hs32_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush discards every entry at once.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/hs32_fetch.sv
// HS32 instruction fetch front-end. Issues in-order word reads from the PC,
// buffers returned words with their bank tag and address, and presents them
// to the pipeline. A redirect flushes the buffer and drops every response
// still owed by memory.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high. valid never depends combinationally on ready of the same interface;
// the memory response side has no ready and must always be accepted.
module hs32_fetch
    import hs32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = HS32_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        redirect_bank_i,
    output logic        mreq_valid_o,
    input  logic        mreq_ready_i,
    output logic [31:0] mreq_addr_o,
    input  logic        mrsp_valid_i,
    input  logic [31:0] mrsp_data_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [31:0] op_o,
    output logic        banksel_o,
    output logic [31:0] pc_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    // Architectural fetch state
    logic [31:0]   pc_q,       pc_d;
    logic [31:0]   rpc_q,      rpc_d;
    logic          bank_q,     bank_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] discard_q,  discard_d;

    // Queue interface
    logic                       fifo_push;
    logic                       fifo_pop;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CW-1:0]              fifo_count;
    logic [HS32_FETCHPKT_W-1:0] fifo_din;
    logic [HS32_FETCHPKT_W-1:0] fifo_dout;
    hs32_fetchpkt               push_pkt;
    hs32_fetchpkt               head_pkt;

    // Handshake / credit terms
    logic [CW:0]   credits_used;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_keep;
    logic [31:0]   redirect_pc_aligned;

    // Every outstanding request owns a queue slot, so a response can always
    // be written without checking for space.
    assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign credit_ok    = (credits_used < (CW + 1)'(DEPTH));

    assign mreq_valid_o = !reset && !redirect_i && credit_ok;
    assign mreq_addr_o  = pc_q;
    assign req_fire     = mreq_valid_o && mreq_ready_i;

    // A response is kept only when no older flush still owes drops and no
    // redirect is happening right now.
    assign rsp_keep = mrsp_valid_i && !redirect_i && (discard_q == '0);

    assign redirect_pc_aligned = hs32_word_align(redirect_pc_i);

    always_comb begin
        push_pkt      = '0;
        push_pkt.op   = mrsp_data_i;
        push_pkt.bank = bank_q;
        push_pkt.pc   = rpc_q;
    end

    assign fifo_din  = push_pkt;
    // Full can never coincide with a kept response; the gate is defensive.
    assign fifo_push = rsp_keep && !fifo_full;
    assign fifo_pop  = valid_o && ready_i && !redirect_i;

    hs32_fifo #(
        .WIDTH (HS32_FETCHPKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_i),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Outputs come only from the registered queue head; zero when empty.
    assign head_pkt  = hs32_fetchpkt'(fifo_dout);
    assign valid_o   = !fifo_empty;
    assign op_o      = valid_o ? head_pkt.op   : 32'h0;
    assign banksel_o = valid_o ? head_pkt.bank : 1'b0;
    assign pc_o      = valid_o ? head_pkt.pc   : 32'h0;

    // Next-state for PC, response PC, bank and the two counters.
    always_comb begin
        pc_d       = pc_q;
        rpc_d      = rpc_q;
        bank_d     = bank_q;
        inflight_d = inflight_q;
        discard_d  = discard_q;

        // Outstanding count moves on every request and every response,
        // including ones that end up dropped.
        if (req_fire) begin
            inflight_d = inflight_d + CW'(1);
        end
        if (mrsp_valid_i) begin
            inflight_d = inflight_d - CW'(1);
        end

        if (redirect_i) begin
            // Everything still owed by memory after this cycle is stale; a
            // response arriving now is dropped on the spot.
            pc_d      = redirect_pc_aligned;
            rpc_d     = redirect_pc_aligned;
            bank_d    = redirect_bank_i;
            discard_d = inflight_q - CW'(mrsp_valid_i);
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (mrsp_valid_i && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (rsp_keep) begin
                rpc_d = rpc_q + 32'd4;
            end
        end
    end

    // Fetch state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            rpc_q      <= RESET_PC;
            bank_q     <= 1'b0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            rpc_q      <= rpc_d;
            bank_q     <= bank_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

endmodule

// File: doc/hs32_fetch.md
# hs32_fetch

Instruction fetch front-end for the HS32 core. Generates sequential word addresses from a program counter, issues in-order read requests to instruction memory, buffers returned words in a small queue, and presents them on a valid/ready stream that feeds the pipeline's instruction input (`op`, `banksel`). It supports a redirect (branch/exception) that flushes buffered and in-flight fetches.

## Interface
- `DEPTH`, 4: queue entries and maximum outstanding requests; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000: PC loaded at reset; word aligned.

- `clk`  in  1  clock
- `reset`  in  1  reset; one clock, synchronous, active-high
- `redirect_i`  in  1  flush and restart fetch
- `redirect_pc_i`  in  32  new PC; bits [1:0] ignored, treated as 0
- `redirect_bank_i`  in  1  register bank for instructions after the redirect
- `mreq_valid_o`  out  1  read request valid
- `mreq_ready_i`  in  1  memory accepts request
- `mreq_addr_o`  out  32  word-aligned request address
- `mrsp_valid_i`  in  1  read data valid; in request order; no backpressure
- `mrsp_data_i`  in  32  read data
- `valid_o`  out  1  instruction available
- `ready_i`  in  1  pipeline accepts instruction
- `op_o`  out  32  instruction word
- `banksel_o`  out  1  bank tag for `op_o`
- `pc_o`  out  32  address `op_o` was fetched from

## Operation
- State: `pc`, `bank`, `inflight` and `discard` counters (each $clog2(DEPTH)+1 bits), and a FIFO of {op, bank, pc}.
- Credit rule: `mreq_valid_o = !reset && !redirect_i && (inflight + count < DEPTH)`. Space is reserved for every response, so a response never overflows the FIFO.
- Request handshake (`mreq_valid_o && mreq_ready_i`) advances `pc` by 4 and increments `inflight`. `pc` wraps from 32'hFFFF_FFFC to 0.
- `mreq_addr_o = pc`. It may change only after a handshake or a redirect.
- Each response decrements `inflight`. If `discard != 0`, the response is dropped and `discard` is decremented. Otherwise it is enqueued with the current `bank` and the pc of its request (tracked by a second counter, `rpc`).
- Redirect, same cycle:
  - Empty the FIFO.
  - Set `discard` to the in-flight count after accounting for any response arriving in this cycle. A response arriving in the redirect cycle is itself dropped.
  - Load `pc` and `rpc` with `{redirect_pc_i[31:2],2'b00}`; set `bank` from `redirect_bank_i`.
  - `valid_o` is 0 the next cycle.
- Output handshake (`valid_o && ready_i`) pops the FIFO. `valid_o` equals FIFO non-empty. Output fields come from the FIFO head, with no combinational path from `mrsp_*` to the outputs.
- A pop and an enqueue in the same cycle are both honoured. A full FIFO cannot receive a response (guaranteed by the credit rule).
- `redirect_i` has priority over pop, enqueue and request in the same cycle.
- Reset mid-operation: clear all state. Responses to requests issued before reset are not tracked. The memory side must itself be reset together with this block.
- Reset values:
  - `mreq_valid_o=0`, `mreq_addr_o=RESET_PC`.
  - `valid_o=0`, `op_o`/`pc_o`=0, `banksel_o=0`.
  - `pc=RESET_PC`, `bank=0`, `inflight=discard=0`.

## Timing
- First request: `mreq_valid_o=1` in the first cycle after `reset` deasserts.
- Response accepted at cycle M → `valid_o=1` at M+1 (one-cycle FIFO write latency, no bypass).
- Redirect at cycle N → `mreq_valid_o` low in N; first request at the new PC in N+1 if credits allow.
- Sustained throughput: one instruction per cycle when memory returns one response per cycle and `ready_i=1`. DEPTH ≥ memory latency + 1 is required for full rate.
- Memory response latency ≥1 cycle after the request handshake.

## Structure
- Shared package (`hs32_pkg`):
  - struct `hs32_fetchpkt` {op[31:0], bank, pc[31:0]};
  - constant `HS32_RESET_PC` as the default for `RESET_PC`.
- One sub-module: `hs32_fifo`, a synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, flush, full, empty and count. It is placed in the shared primitives file.
- Counters, PC logic and credit logic live in `hs32_fetch`. Target size is about 200 lines total.

## Test plan
- Reset release, memory with 1-cycle latency, `ready_i=1`: requests at 0x0, 0x4, 0x8 on consecutive cycles → `op_o` stream equals memory words in order with `pc_o` 0,4,8; one op per cycle after a 2-cycle fill.
- `ready_i=0` for 20 cycles, DEPTH=4: exactly 4 requests issued, then `mreq_valid_o=0`. On release, 4 ops drain in order and issue resumes.
- Two requests in flight (0x10, 0x14), then redirect to 0x100 with bank 1: both responses dropped; next `op_o` has `pc_o`=0x100 and `banksel_o`=1; `discard` returns to 0.
- Redirect in the same cycle as a response and a pop: response dropped, FIFO empty, `valid_o=0` next cycle, `mreq_addr_o`=new PC.
- PC wrap: redirect to 0xFFFF_FFF8 → fetched `pc_o` sequence FFFF_FFF8, FFFF_FFFC, 0, 4.
- Reset asserted with a full FIFO and 2 requests in flight: next cycle all outputs at their reset values; after release, fetch restarts at `RESET_PC`.
